// File: rtl/sram_arb_pkg.sv
// Shared types and defaults for the two-port SRAM arbiter.
// Imported by sram_port_arbiter and its round-robin picker rr_arb2.
package sram_arb_pkg;

    localparam int DEF_ADDR_W = 10;
    localparam int DEF_DATA_W = 32;
    localparam int DEF_MASK_W = 4;

    localparam int REQ0 = 0;
    localparam int REQ1 = 1;

    typedef enum logic {
        ST_INIT,
        ST_RUN
    } state_e;

    // ptr = 0 prefers requester 0 when both ask
    function automatic logic [1:0] rr_pick(
        input logic [1:0] valid,
        input logic       ptr
    );
        logic [1:0] g;
        g = 2'b00;
        unique case (1'b1)
            (valid == 2'b11): g = ptr ? 2'b10 : 2'b01;
            (valid == 2'b01): g = 2'b01;
            (valid == 2'b10): g = 2'b10;
            default:          g = 2'b00;
        endcase
        return g;
    endfunction

endpackage

// File: rtl/sram_port_arbiter_rr_arb2.sv
// Two-way round-robin picker with a one-hot grant.
// The pointer moves only when both requesters compete.
module rr_arb2
    import sram_arb_pkg::*;
(
    input  logic       clock,
    input  logic       reset,
    input  logic       enable,
    input  logic [1:0] valid,
    output logic [1:0] grant
);

    logic ptr_q;

    assign grant = enable ? rr_pick(valid, ptr_q) : 2'b00;

    always_ff @(posedge clock) begin
        if (reset) begin
            ptr_q <= 1'b0;
        end else if (enable && valid == 2'b11) begin
            ptr_q <= ~ptr_q;
        end
    end

endmodule

// File: rtl/sram_port_arbiter.sv
// Round-robin sharing of one RW0 SRAM macro between two requesters.
// Define SRAM_ARB_INIT_CLEAR_EN to zero the whole macro after reset.
module sram_port_arbiter
    import sram_arb_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W,
    parameter int MASK_W = DEF_MASK_W
) (
    input  logic              clock,
    input  logic              reset,

    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic              req0_write,
    input  logic [ADDR_W-1:0] req0_addr,
    input  logic [DATA_W-1:0] req0_wdata,
    input  logic [MASK_W-1:0] req0_wmask,
    output logic              resp0_valid,
    output logic [DATA_W-1:0] resp0_rdata,

    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic              req1_write,
    input  logic [ADDR_W-1:0] req1_addr,
    input  logic [DATA_W-1:0] req1_wdata,
    input  logic [MASK_W-1:0] req1_wmask,
    output logic              resp1_valid,
    output logic [DATA_W-1:0] resp1_rdata,

    output logic              mem_en,
    output logic              mem_wmode,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [MASK_W-1:0] mem_wmask,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,

    output logic              init_busy
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = {ADDR_W{1'b1}};

`ifdef SRAM_ARB_INIT_CLEAR_EN
    localparam state_e RST_STATE = ST_INIT;
`else
    localparam state_e RST_STATE = ST_RUN;
`endif

    state_e            state_q;
    state_e            state_d;
    logic              run;
    logic              init_act;
    logic [ADDR_W-1:0] cnt_q;
    logic [1:0]        grant;

    logic              drv_en;
    logic              drv_wmode;
    logic [ADDR_W-1:0] drv_addr;
    logic [MASK_W-1:0] drv_wmask;
    logic [DATA_W-1:0] drv_wdata;

    logic              wmode_q;
    logic [ADDR_W-1:0] addr_q;
    logic [MASK_W-1:0] wmask_q;
    logic [DATA_W-1:0] wdata_q;

    logic [1:0]        resp_q;
    logic [DATA_W-1:0] rdata0_q;
    logic [DATA_W-1:0] rdata1_q;

    // Reset aborts whatever the current cycle would have done
    assign run = (state_q == ST_RUN) && !reset;

`ifdef SRAM_ARB_INIT_CLEAR_EN
    assign init_act  = (state_q == ST_INIT) && !reset;
    assign init_busy = (state_q == ST_INIT);

    always_ff @(posedge clock) begin
        if (reset) begin
            cnt_q <= '0;
        end else if (init_act) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end
`else
    assign init_act  = 1'b0;
    assign init_busy = 1'b0;
    assign cnt_q     = '0;
`endif

    rr_arb2 u_arb (
        .clock  (clock),
        .reset  (reset),
        .enable (run),
        .valid  ({req1_valid, req0_valid}),
        .grant  (grant)
    );

    assign req0_ready = grant[REQ0];
    assign req1_ready = grant[REQ1];

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= RST_STATE;
        end else begin
            state_q <= state_d;
        end
    end

    // Idle cycles replay the held pin values so the macro inputs stay quiet
    always_comb begin
        state_d   = state_q;
        drv_en    = 1'b0;
        drv_wmode = wmode_q;
        drv_addr  = addr_q;
        drv_wmask = wmask_q;
        drv_wdata = wdata_q;
        unique case (1'b1)
            init_act: begin
                drv_en    = 1'b1;
                drv_wmode = 1'b1;
                drv_addr  = cnt_q;
                drv_wmask = '1;
                drv_wdata = '0;
                if (cnt_q == LAST_ADDR) begin
                    state_d = ST_RUN;
                end
            end
            grant[REQ0]: begin
                drv_en    = 1'b1;
                drv_wmode = req0_write;
                drv_addr  = req0_addr;
                drv_wmask = req0_write ? req0_wmask : '1;
                drv_wdata = req0_wdata;
            end
            grant[REQ1]: begin
                drv_en    = 1'b1;
                drv_wmode = req1_write;
                drv_addr  = req1_addr;
                drv_wmask = req1_write ? req1_wmask : '1;
                drv_wdata = req1_wdata;
            end
            default: ;
        endcase
    end

    assign mem_en    = drv_en;
    assign mem_wmode = drv_wmode;
    assign mem_addr  = drv_addr;
    assign mem_wmask = drv_wmask;
    assign mem_wdata = drv_wdata;

    always_ff @(posedge clock) begin
        if (reset) begin
            wmode_q  <= 1'b0;
            addr_q   <= '0;
            wmask_q  <= '0;
            wdata_q  <= '0;
            resp_q   <= 2'b00;
            rdata0_q <= '0;
            rdata1_q <= '0;
        end else begin
            if (drv_en) begin
                wmode_q <= drv_wmode;
                addr_q  <= drv_addr;
                wmask_q <= drv_wmask;
                wdata_q <= drv_wdata;
            end
            resp_q[REQ0] <= grant[REQ0] && !req0_write;
            resp_q[REQ1] <= grant[REQ1] && !req1_write;
            if (resp_q[REQ0]) begin
                rdata0_q <= mem_rdata;
            end
            if (resp_q[REQ1]) begin
                rdata1_q <= mem_rdata;
            end
        end
    end

    // Macro data arrives in the response cycle; pass it straight through
    assign resp0_valid = resp_q[REQ0] && !reset;
    assign resp1_valid = resp_q[REQ1] && !reset;
    assign resp0_rdata = resp0_valid ? mem_rdata : rdata0_q;
    assign resp1_rdata = resp1_valid ? mem_rdata : rdata1_q;

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Randomised scoreboard bench for sram_port_arbiter with an SRAM macro model.
// Also exercises the clear sweep when SRAM_ARB_INIT_CLEAR_EN is defined.
module tb_sram_port_arbiter;
    import sram_arb_pkg::*;

    localparam int AW    = DEF_ADDR_W;
    localparam int DW    = DEF_DATA_W;
    localparam int MW    = DEF_MASK_W;
    localparam int DEPTH = 1 << AW;
    localparam int LW    = DW / MW;

    typedef struct {
        logic          w;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        logic [MW-1:0] m;
    } cmd_t;

    typedef struct {
        logic [DW-1:0] d;
        int            cyc;
    } exp_t;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          req0_valid, req0_ready, req0_write;
    logic [AW-1:0] req0_addr;
    logic [DW-1:0] req0_wdata;
    logic [MW-1:0] req0_wmask;
    logic          resp0_valid;
    logic [DW-1:0] resp0_rdata;
    logic          req1_valid, req1_ready, req1_write;
    logic [AW-1:0] req1_addr;
    logic [DW-1:0] req1_wdata;
    logic [MW-1:0] req1_wmask;
    logic          resp1_valid;
    logic [DW-1:0] resp1_rdata;
    logic          mem_en, mem_wmode;
    logic [AW-1:0] mem_addr;
    logic [MW-1:0] mem_wmask;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic          init_busy;

    always #5 clock = ~clock;

    sram_port_arbiter dut (
        .clock       (clock),
        .reset       (reset),
        .req0_valid  (req0_valid),
        .req0_ready  (req0_ready),
        .req0_write  (req0_write),
        .req0_addr   (req0_addr),
        .req0_wdata  (req0_wdata),
        .req0_wmask  (req0_wmask),
        .resp0_valid (resp0_valid),
        .resp0_rdata (resp0_rdata),
        .req1_valid  (req1_valid),
        .req1_ready  (req1_ready),
        .req1_write  (req1_write),
        .req1_addr   (req1_addr),
        .req1_wdata  (req1_wdata),
        .req1_wmask  (req1_wmask),
        .resp1_valid (resp1_valid),
        .resp1_rdata (resp1_rdata),
        .mem_en      (mem_en),
        .mem_wmode   (mem_wmode),
        .mem_addr    (mem_addr),
        .mem_wmask   (mem_wmask),
        .mem_wdata   (mem_wdata),
        .mem_rdata   (mem_rdata),
        .init_busy   (init_busy)
    );

    function automatic logic [DW-1:0] pat(input int i);
        return (32'(i) * 32'h9E3779B1) ^ 32'h00C0FFEE;
    endfunction

    // RW0 macro: registered read address, byte-masked writes
    logic [DW-1:0] sram [DEPTH];
    logic [AW-1:0] raddr = '0;
    assign mem_rdata = sram[raddr];

    initial begin
        for (int i = 0; i < DEPTH; i++) sram[i] = pat(i);
        forever begin
            @(posedge clock);
            if (mem_en) begin
                if (mem_wmode) begin
                    for (int b = 0; b < MW; b++) begin
                        if (mem_wmask[b]) sram[mem_addr][b*LW +: LW] <= mem_wdata[b*LW +: LW];
                    end
                end else begin
                    raddr <= mem_addr;
                end
            end
        end
    end

    int ncmp = 0;
    int nbad = 0;
    int cyc  = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        ncmp++;
        if (act !== exp) begin
            nbad++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Reference: ideal word memory, fixed-latency responses, fair alternation
    logic [DW-1:0] ref_mem [DEPTH];
    exp_t          q0[$];
    exp_t          q1[$];
    logic [DW-1:0] last_rd [2];
    logic [AW-1:0] last_addr;
    int            pref;
    int            init_left;

    task automatic chk_resp(input int r, input logic v, input logic [DW-1:0] rd);
        exp_t e;
        logic ev;
        if (r == 0) ev = (q0.size() > 0) && (q0[0].cyc == cyc);
        else        ev = (q1.size() > 0) && (q1[0].cyc == cyc);
        chk($sformatf("resp%0d_valid", r), 64'(v), 64'(ev));
        if (ev) begin
            if (r == 0) e = q0.pop_front();
            else        e = q1.pop_front();
            if (v) begin
                chk($sformatf("resp%0d_rdata", r), 64'(rd), 64'(e.d));
                last_rd[r] = e.d;
            end
        end else if (!v) begin
            chk($sformatf("resp%0d_rdata_hold", r), 64'(rd), 64'(last_rd[r]));
        end
    endtask

    initial begin
        int   g;
        cmd_t c;
        exp_t e;
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = pat(i);
        pref = 0;
        init_left = 0;
        last_addr = '0;
        last_rd[0] = '0;
        last_rd[1] = '0;
        forever begin
            @(negedge clock);
            cyc++;
            if (reset) begin
                chk("rst_resp0_valid", 64'(resp0_valid), 64'(0));
                chk("rst_resp1_valid", 64'(resp1_valid), 64'(0));
                chk("rst_req0_ready", 64'(req0_ready), 64'(0));
                chk("rst_req1_ready", 64'(req1_ready), 64'(0));
                chk("rst_mem_en", 64'(mem_en), 64'(0));
                q0.delete();
                q1.delete();
                pref = 0;
                last_addr = '0;
                last_rd[0] = '0;
                last_rd[1] = '0;
`ifdef SRAM_ARB_INIT_CLEAR_EN
                init_left = DEPTH;
                for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
`endif
            end else begin
                chk("init_busy", 64'(init_busy), 64'(init_left > 0));
                if (init_left > 0) begin
                    chk("init_ready0", 64'(req0_ready), 64'(0));
                    chk("init_ready1", 64'(req1_ready), 64'(0));
                    chk("init_mem_en", 64'(mem_en), 64'(1));
                    chk("init_wmode", 64'(mem_wmode), 64'(1));
                    chk("init_addr", 64'(mem_addr), 64'(DEPTH - init_left));
                    chk("init_wmask", 64'(mem_wmask), 64'({MW{1'b1}}));
                    chk("init_wdata", 64'(mem_wdata), 64'(0));
                    last_addr = AW'(DEPTH - init_left);
                    init_left--;
                end else begin
                    chk_resp(0, resp0_valid, resp0_rdata);
                    chk_resp(1, resp1_valid, resp1_rdata);
                    g = -1;
                    if (req0_valid && req1_valid) begin
                        g = pref;
                        pref = 1 - pref;
                    end else if (req0_valid) begin
                        g = 0;
                    end else if (req1_valid) begin
                        g = 1;
                    end
                    chk("req0_ready", 64'(req0_ready), 64'(g == 0));
                    chk("req1_ready", 64'(req1_ready), 64'(g == 1));
                    chk("mem_en", 64'(mem_en), 64'(g >= 0));
                    if (g >= 0) begin
                        c.w = (g == 1) ? req1_write : req0_write;
                        c.a = (g == 1) ? req1_addr  : req0_addr;
                        c.d = (g == 1) ? req1_wdata : req0_wdata;
                        c.m = (g == 1) ? req1_wmask : req0_wmask;
                        chk("mem_wmode", 64'(mem_wmode), 64'(c.w));
                        chk("mem_addr", 64'(mem_addr), 64'(c.a));
                        chk("mem_wdata", 64'(mem_wdata), 64'(c.d));
                        chk("mem_wmask", 64'(mem_wmask), 64'(c.w ? c.m : {MW{1'b1}}));
                        last_addr = c.a;
                        if (c.w) begin
                            for (int b = 0; b < MW; b++) begin
                                if (c.m[b]) ref_mem[c.a][b*LW +: LW] = c.d[b*LW +: LW];
                            end
                        end else begin
                            e.d = ref_mem[c.a];
                            e.cyc = cyc + 1;
                            if (g == 1) q1.push_back(e);
                            else        q0.push_back(e);
                        end
                    end else begin
                        chk("mem_addr_hold", 64'(mem_addr), 64'(last_addr));
                    end
                end
            end
        end
    end

    // Stimulus side: per-requester command queues, valid held until accepted
    cmd_t cq0[$];
    cmd_t cq1[$];
    cmd_t cur [2];
    logic busy [2];
    logic acc [2];

    function automatic cmd_t mk(input logic w, input logic [AW-1:0] a,
                                input logic [DW-1:0] d, input logic [MW-1:0] m);
        cmd_t c;
        c.w = w;
        c.a = a;
        c.d = d;
        c.m = m;
        return c;
    endfunction

    function automatic cmd_t rnd();
        logic [AW-1:0] a;
        if ($urandom_range(0, 7) == 0) a = AW'($urandom);
        else                           a = AW'($urandom_range(0, 15));
        return mk(1'($urandom_range(0, 1)), a, $urandom, MW'($urandom));
    endfunction

    task automatic apply();
        req0_valid = busy[0];
        req0_write = cur[0].w;
        req0_addr  = cur[0].a;
        req0_wdata = cur[0].d;
        req0_wmask = cur[0].m;
        req1_valid = busy[1];
        req1_write = cur[1].w;
        req1_addr  = cur[1].a;
        req1_wdata = cur[1].d;
        req1_wmask = cur[1].m;
    endtask

    task automatic step();
        @(posedge clock);
        #1;
        if (busy[0] && acc[0]) busy[0] = 1'b0;
        if (busy[1] && acc[1]) busy[1] = 1'b0;
        if (!busy[0] && cq0.size() > 0) begin
            cur[0] = cq0.pop_front();
            busy[0] = 1'b1;
        end
        if (!busy[1] && cq1.size() > 0) begin
            cur[1] = cq1.pop_front();
            busy[1] = 1'b1;
        end
        apply();
        @(negedge clock);
        acc[0] = req0_valid && req0_ready;
        acc[1] = req1_valid && req1_ready;
    endtask

    task automatic drain();
        int n = 0;
        while ((cq0.size() > 0 || cq1.size() > 0 ||
                (busy[0] && !acc[0]) || (busy[1] && !acc[1])) && n < 500) begin
            step();
            n++;
        end
        chk("drain_in_time", 64'(n < 500), 64'(1));
        repeat (3) step();
    endtask

    task automatic do_reset(input int n);
        @(posedge clock);
        #1;
        reset = 1'b1;
        busy[0] = 1'b0;
        busy[1] = 1'b0;
        acc[0] = 1'b0;
        acc[1] = 1'b0;
        cq0.delete();
        cq1.delete();
        apply();
        repeat (n) @(posedge clock);
        #1;
        reset = 1'b0;
    endtask

`ifdef SRAM_ARB_INIT_CLEAR_EN
    task automatic wait_init(input int stop_at, output int n);
        n = 0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clock);
            if (!init_busy) break;
            n++;
            if (n == stop_at) break;
        end
    endtask
`endif

    initial begin
        int n;
        for (int r = 0; r < 2; r++) begin
            cur[r] = mk(1'b0, '0, '0, '0);
            busy[r] = 1'b0;
            acc[r] = 1'b0;
        end
        apply();
        do_reset(3);
`ifdef SRAM_ARB_INIT_CLEAR_EN
        wait_init(0, n);
        chk("init_cycles", 64'(n), 64'(DEPTH));
        cq0.push_back(mk(1'b0, 10'h3FF, '0, '0));
        drain();
        do_reset(1);
        wait_init(10'h200, n);
        do_reset(1);
        wait_init(0, n);
        chk("init_restart_cycles", 64'(n), 64'(DEPTH));
`endif
        cq0.push_back(mk(1'b0, 10'h005, '0, '0));
        drain();
        cq0.push_back(mk(1'b1, 10'h010, 32'h12345678, 4'b0101));
        cq0.push_back(mk(1'b0, 10'h010, '0, '0));
        drain();
        cq0.push_back(mk(1'b0, 10'h001, '0, '0));
        cq0.push_back(mk(1'b0, 10'h003, '0, '0));
        cq1.push_back(mk(1'b0, 10'h002, '0, '0));
        cq1.push_back(mk(1'b0, 10'h004, '0, '0));
        drain();
        cq0.push_back(mk(1'b1, 10'h020, 32'hAAAA5555, 4'b1111));
        cq0.push_back(mk(1'b0, 10'h020, '0, '0));
        cq1.push_back(mk(1'b0, 10'h030, '0, '0));
        cq1.push_back(mk(1'b1, 10'h030, 32'hDEADBEEF, 4'b1111));
        cq1.push_back(mk(1'b0, 10'h030, '0, '0));
        drain();
        cq1.push_back(mk(1'b0, 10'h005, '0, '0));
        n = 0;
        do begin
            step();
            n++;
        end while (!acc[1] && n < 50);
        chk("outstanding_read_accepted", 64'(acc[1]), 64'(1));
        do_reset(2);
`ifdef SRAM_ARB_INIT_CLEAR_EN
        wait_init(0, n);
`endif
        for (int i = 0; i < 1500; i++) begin
            if (cq0.size() == 0 && $urandom_range(0, 9) < 6) cq0.push_back(rnd());
            if (cq1.size() == 0 && $urandom_range(0, 9) < 6) cq1.push_back(rnd());
            step();
        end
        drain();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nbad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "watchdog expired");
    end

endmodule
